// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch (IF) and
// load/store (D). Each access runs through a registered FSM:
// IDLE -> IF_ACC/D_ACC -> RESP, or IDLE -> RESP when the address is misaligned.
// Store data is lane-replicated with byte strobes. Load data is extracted and
// sign- or zero-extended. A burst counter bounds how many D grants can starve
// a pending fetch.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   if_req/if_addr               fetch request (level) and byte address
//   if_rdata/if_valid/if_err     fetch result, completion pulse, misaligned flag
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata
//                                load/store request and operands
//   d_rdata/d_valid/d_err        load result, completion pulse, misaligned flag
//   mem_addr/mem_wdata/mem_wstrb/mem_re
//                                registered memory strobes
//   mem_ready/mem_rdata          memory handshake and read data
//   stall                        high while any request is outstanding
module mem_port_arbiter #(
  parameter int MAX_D_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_re,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {S_IDLE, S_IF_ACC, S_D_ACC, S_RESP} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

  state_t      r_state;
  logic [3:0]  r_burst;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_we;

  logic        w_grant_d;
  logic        w_grant_if;
  logic        w_d_mis;
  logic        w_if_mis;

  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   f_misaligned = 1'b0;
      2'b01:   f_misaligned = lo[0];
      default: f_misaligned = |lo;
    endcase
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   f_wstrb = 4'b0001 << lane;
      2'b01:   f_wstrb = 4'b0011 << lane;
      default: f_wstrb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   f_wdata = {4{wd[7:0]}};
      2'b01:   f_wdata = {2{wd[15:0]}};
      default: f_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] size, input logic uns,
                                         input logic [1:0] lane, input logic [31:0] word);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    // Aligned halves only ever sit at lane 0 or 2.
    h  = lane[1] ? word[31:16] : word[15:0];
    sb = b;
    sh = h;
    case (size)
      2'b00:   f_load = uns ? {24'b0, b} : 32'(sb);
      2'b01:   f_load = uns ? {16'b0, h} : 32'(sh);
      default: f_load = word;
    endcase
  endfunction

  // D wins unless a pending fetch has already waited MAX_D_BURST D grants.
  assign w_grant_d  = d_req & ~(if_req & (r_burst == BURST_MAX));
  assign w_grant_if = if_req & ~w_grant_d;
  assign w_d_mis    = f_misaligned(d_size, d_addr[1:0]);
  assign w_if_mis   = |if_addr[1:0];

  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_burst   <= 4'd0;
      r_lane    <= 2'd0;
      r_size    <= 2'd0;
      r_uns     <= 1'b0;
      r_we      <= 1'b0;
      if_rdata  <= 32'd0;
      if_valid  <= 1'b0;
      if_err    <= 1'b0;
      d_rdata   <= 32'd0;
      d_valid   <= 1'b0;
      d_err     <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      mem_re    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      if_err   <= 1'b0;
      d_valid  <= 1'b0;
      d_err    <= 1'b0;
      case (r_state)
        // Grant decision and strobe launch
        S_IDLE: begin
          if (w_grant_d) begin
            r_burst <= !if_req ? 4'd0 :
                       (r_burst == BURST_MAX) ? r_burst : r_burst + 4'd1;
            r_lane  <= d_addr[1:0];
            r_size  <= d_size;
            r_uns   <= d_unsigned;
            r_we    <= d_we;
            if (w_d_mis) begin
              d_valid <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= 32'd0;
              r_state <= S_RESP;
            end else begin
              mem_addr  <= {d_addr[31:2], 2'b00};
              mem_re    <= ~d_we;
              mem_wstrb <= d_we ? f_wstrb(d_size, d_addr[1:0]) : 4'd0;
              mem_wdata <= d_we ? f_wdata(d_size, d_wdata) : 32'd0;
              r_state   <= S_D_ACC;
            end
          end else if (w_grant_if) begin
            r_burst <= 4'd0;
            if (w_if_mis) begin
              if_valid <= 1'b1;
              if_err   <= 1'b1;
              if_rdata <= 32'd0;
              r_state  <= S_RESP;
            end else begin
              mem_addr  <= {if_addr[31:2], 2'b00};
              mem_re    <= 1'b1;
              mem_wstrb <= 4'd0;
              mem_wdata <= 32'd0;
              r_state   <= S_IF_ACC;
            end
          end
        end
        // Fetch access: hold strobes until mem_ready
        S_IF_ACC: begin
          if (mem_ready) begin
            mem_re   <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            r_state  <= S_RESP;
          end
        end
        // Data access: hold strobes until mem_ready
        S_D_ACC: begin
          if (mem_ready) begin
            mem_re    <= 1'b0;
            mem_wstrb <= 4'd0;
            d_rdata   <= r_we ? 32'd0 : f_load(r_size, r_uns, r_lane, mem_rdata);
            d_valid   <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        // Response pulse; requests ignored
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses with a per-access
// scoreboard, plus sequences for reset state, IF/D contention with wait states,
// and reset in the middle of an access.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_re;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_D_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_re(mem_re), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  typedef struct packed {
    logic        is_if;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic [7:0]  delay;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [3:0]  e_wstrb;
    logic        e_re;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[14];

  function automatic vec_t mk(input logic is_if, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mrdata, input logic [7:0] delay,
                              input logic [31:0] e_rdata, input logic e_err,
                              input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
                              input logic [3:0] e_wstrb, input logic e_re);
    vec_t v;
    v.is_if = is_if; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.mrdata = mrdata; v.delay = delay; v.e_rdata = e_rdata;
    v.e_err = e_err; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_wstrb = e_wstrb; v.e_re = e_re;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_access(input int idx, input vec_t v);
    vec_t  e;
    int    strobes;
    bit    done;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is_if) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      d_req      = 1'b1;
      d_we       = v.we;
      d_size     = v.size;
      d_unsigned = v.uns;
      d_addr     = v.addr;
      d_wdata    = v.wdata;
    end
    mem_ready = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    sb.push_back(v);
    #1 chk({tag, " stall_start"}, {31'b0, stall}, 32'd1);
    strobes = 0;
    done    = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (if_valid | d_valid) begin
        e = sb.pop_front();
        chk({tag, " valid_sel"}, {31'b0, if_valid}, {31'b0, e.is_if});
        chk({tag, " rdata"}, e.is_if ? if_rdata : d_rdata, e.e_rdata);
        chk({tag, " err"}, {31'b0, e.is_if ? if_err : d_err}, {31'b0, e.e_err});
        chk({tag, " latency"}, 32'(k), e.e_err ? 32'd1 : 32'(e.delay) + 32'd2);
        chk({tag, " strobe_cycles"}, 32'(strobes), e.e_err ? 32'd0 : 32'(e.delay) + 32'd1);
        chk({tag, " stall_at_valid"}, {31'b0, stall}, 32'd0);
        done = 1'b1;
      end else begin
        chk({tag, " stall_wait"}, {31'b0, stall}, 32'd1);
        if (mem_re | (|mem_wstrb)) begin
          strobes++;
          chk({tag, " mem_addr"}, mem_addr, v.e_maddr);
          chk({tag, " mem_wstrb"}, {28'b0, mem_wstrb}, {28'b0, v.e_wstrb});
          chk({tag, " mem_re"}, {31'b0, mem_re}, {31'b0, v.e_re});
          if (v.we && !v.is_if) chk({tag, " mem_wdata"}, mem_wdata, v.e_mwdata);
          if (strobes == int'(v.delay) + 1) begin
            mem_ready = 1'b1;
            mem_rdata = v.mrdata;
          end
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no valid pulse within 20 cycles", tag);
      void'(sb.pop_front());
    end
    if_req    = 1'b0;
    d_req     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, " valid_pulse_end"}, {30'b0, if_valid, d_valid}, 32'd0);
  endtask

  initial begin
    bit     gq[$];
    bit     g;
    int     got;
    int     strobes;
    logic [31:0] snap_addr;
    logic        snap_re;

    // Vectors: is_if we size uns addr wdata mrdata delay | rdata err maddr mwdata wstrb re
    vecs[0]  = mk(1, 0, 2'b10, 0, 32'h100, 0, 32'h00A00093, 1, 32'h00A00093, 0, 32'h100, 0, 4'h0, 1);
    vecs[1]  = mk(0, 0, 2'b00, 0, 32'h203, 0, 32'h80FF1122, 0, 32'hFFFFFF80, 0, 32'h200, 0, 4'h0, 1);
    vecs[2]  = mk(0, 0, 2'b00, 1, 32'h203, 0, 32'h80FF1122, 0, 32'h00000080, 0, 32'h200, 0, 4'h0, 1);
    vecs[3]  = mk(0, 1, 2'b01, 0, 32'h12, 32'h0000BEEF, 0, 0, 32'h0, 0, 32'h10, 32'hBEEFBEEF, 4'hC, 0);
    vecs[4]  = mk(0, 1, 2'b00, 0, 32'h201, 32'h123456A5, 0, 2, 32'h0, 0, 32'h200, 32'hA5A5A5A5, 4'h2, 0);
    vecs[5]  = mk(0, 1, 2'b10, 0, 32'h300, 32'hCAFEF00D, 0, 0, 32'h0, 0, 32'h300, 32'hCAFEF00D, 4'hF, 0);
    vecs[6]  = mk(0, 0, 2'b01, 0, 32'h402, 0, 32'h9ABC1234, 3, 32'hFFFF9ABC, 0, 32'h400, 0, 4'h0, 1);
    vecs[7]  = mk(0, 0, 2'b01, 1, 32'h400, 0, 32'h9ABC8001, 1, 32'h00008001, 0, 32'h400, 0, 4'h0, 1);
    vecs[8]  = mk(0, 0, 2'b11, 0, 32'h500, 0, 32'h87654321, 0, 32'h87654321, 0, 32'h500, 0, 4'h0, 1);
    vecs[9]  = mk(0, 0, 2'b00, 0, 32'h601, 0, 32'h11227F44, 0, 32'h0000007F, 0, 32'h600, 0, 4'h0, 1);
    vecs[10] = mk(0, 0, 2'b10, 0, 32'h6, 0, 0, 0, 32'h0, 1, 32'h0, 0, 4'h0, 0);
    vecs[11] = mk(0, 1, 2'b01, 0, 32'h13, 32'h1234, 0, 0, 32'h0, 1, 32'h0, 0, 4'h0, 0);
    vecs[12] = mk(1, 0, 2'b10, 0, 32'h102, 0, 0, 0, 32'h0, 1, 32'h0, 0, 4'h0, 0);
    vecs[13] = mk(0, 1, 2'b01, 0, 32'h20, 32'hFFFF1234, 0, 1, 32'h0, 0, 32'h20, 32'h12341234, 4'h3, 0);

    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0;
    d_unsigned = 0; d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {if_rdata ^ d_rdata, 28'b0, if_valid, if_err, d_valid, d_err}, 32'd0);
    chk("reset strobes", {27'b0, mem_wstrb, mem_re}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_access(i, vecs[i]);

    // Contention: both held high; expect D,D,D,D,IF,D with 3 wait states each
    gq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if_req = 1'b1; if_addr = 32'h800;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h900;
    mem_ready = 1'b0;
    got = 0; strobes = 0; snap_addr = 0; snap_re = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (if_valid | d_valid) begin
        g = gq.pop_front();
        chk($sformatf("contend grant%0d is_if", got), {31'b0, if_valid}, {31'b0, g});
        chk($sformatf("contend grant%0d single", got), {31'b0, if_valid & d_valid}, 32'd0);
        chk($sformatf("contend grant%0d rdata", got), g ? if_rdata : d_rdata,
            g ? 32'h11111111 : 32'h22222222);
        got++;
        strobes = 0;
      end else if (mem_re | (|mem_wstrb)) begin
        if (strobes == 0) begin
          snap_addr = mem_addr;
          snap_re   = mem_re;
        end else begin
          chk($sformatf("contend grant%0d addr stable", got), mem_addr, snap_addr);
          chk($sformatf("contend grant%0d re stable", got), {31'b0, mem_re}, {31'b0, snap_re});
        end
        strobes++;
        if (strobes == 4) begin
          mem_ready = 1'b1;
          mem_rdata = (mem_addr == 32'h800) ? 32'h11111111 : 32'h22222222;
        end
      end
    end
    chk("contend grants completed", 32'(got), 32'd6);
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h700;
    @(negedge clk);
    chk("midrst strobe before", {31'b0, mem_re}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    chk("midrst strobes cleared", {27'b0, mem_wstrb, mem_re}, 32'd0);
    chk("midrst rdata cleared", if_rdata | d_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst quiet%0d", i), {29'b0, d_valid, if_valid, mem_re}, 32'd0);
    end
    run_access(100, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-ported unified memory between instruction fetch (IF) and load/store (D) requesters.
- Sequences each access through a registered FSM with a memory ready handshake.
- Performs byte-lane steering, write-strobe generation, load sign/zero extension and misalignment detection.
- Drives a pipeline stall while any request is outstanding.

Parameters:
- MAX_D_BURST, 4, maximum consecutive D grants while IF is pending before IF is forced a grant (range 1..15).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level; held with if_addr until if_valid
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction word
- if_valid  out  1  one-cycle completion pulse for fetch
- if_err  out  1  fetch misaligned; valid only with if_valid
- d_req  in  1  load/store request, level; operands held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- d_unsigned  in  1  load zero-extends when 1
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_rdata  out  32  extended load result (0 for stores)
- d_valid  out  1  one-cycle completion pulse for data
- d_err  out  1  data misaligned; valid only with d_valid
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte write enables; 0 on reads
- mem_re  out  1  read strobe
- mem_ready  in  1  memory completes the current access in the cycle it is high
- mem_rdata  in  32  read word; valid when mem_ready=1
- stall  out  1  (if_req & ~if_valid) | (d_req & ~d_valid), combinational

Behaviour:
- States and transitions:
  - IDLE: samples requests and decides a grant.
    - Grant goes to D if d_req, unless IF is pending and the burst counter equals MAX_D_BURST, in which case IF wins. Otherwise IF wins if if_req.
    - No request: remain in IDLE.
  - IF_ACC / D_ACC: mem_addr, mem_re, mem_wstrb and mem_wdata are registered and stable.
    - Strobes are asserted from the cycle after the grant until the cycle in which mem_ready=1 is sampled.
  - RESP: the valid pulse is asserted together with rdata/err. All requests are ignored this cycle. Next state is IDLE.
- Latency: request seen in IDLE at cycle N; strobes asserted at N+1; mem_ready sampled high at cycle M ≥ N+1; valid pulse at M+1; next grant decided at M+2. Minimum is 3 cycles per access.
- Misaligned access: half with addr[0]=1, word with addr[1:0]≠0, or fetch with addr[1:0]≠0.
  - No memory strobes are issued; the FSM goes IDLE→RESP directly.
  - Valid is raised with err=1 at N+1; rdata=0.
- Store lanes:
  - Byte: wdata = {4{d_wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - Half: wdata = {2{d_wdata[15:0]}}, wstrb = 0011 << addr[1:0].
  - Word: wdata = d_wdata, wstrb = 1111.
- Load extraction: select the byte or half from mem_rdata by addr[1:0], then sign-extend, or zero-extend if d_unsigned. Word loads pass through unchanged.
- Burst counter:
  - Increments on each D grant while if_req=1, saturating at MAX_D_BURST.
  - Clears on any IF grant, and whenever IF is not pending at a D grant.
- Outputs outside RESP: valid, err=0. rdata holds its last value.
- Reset: all outputs, mem strobes, if_rdata and d_rdata go to 0; state IDLE; counter 0.
  - Reset mid-access abandons the transaction. Memory must tolerate strobe removal.
- Simultaneous if_req and d_req in IDLE are resolved by the priority rule above; exactly one grant is issued.
- A request deasserted before its grant is dropped silently.
- Requests deasserted mid-access are a protocol violation; behaviour is undefined.

Test Plan:
- Word fetch: if_addr=0x100, mem_ready one cycle after strobe, mem_rdata=0x00A00093 → if_valid at cycle 3 with if_rdata=0x00A00093, if_err=0, stall high cycles 0–2.
- Signed byte load: d_addr=0x203, d_size=00, d_unsigned=0, mem_rdata=0x80FF1122 → d_rdata=0xFFFFFF80. Repeat with d_unsigned=1 → 0x00000080.
- Half store: d_addr=0x12, d_wdata=0x0000BEEF → mem_addr=0x10, mem_wstrb=1100, mem_wdata=0xBEEFBEEF, mem_re=0.
- Misaligned: word load at d_addr=0x6 → d_valid and d_err at N+1, mem_re and mem_wstrb never asserted.
- Contention with MAX_D_BURST=4: if_req and d_req held high → grant order D,D,D,D,IF,D,… Check wait states (mem_ready delayed 3 cycles) keep strobes stable.
- Assert rst during D_ACC → next cycle state IDLE, all strobes 0, no valid pulse. A subsequent fetch completes normally.
